// File: rtl/i2c_target_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_rx
//
// Write-only I2C target. Oversamples SCL/SDA with the system clock, detects
// START/STOP and SCL edges, receives an address byte and any number of data
// bytes, and ACKs each byte by pulling SDA low (open drain). Reads are NACKed
// simply by never driving the bus.
//
// Parameters
//   TARGET_ADDR  7-bit address this block answers to
//   SYNC_STAGES  synchronizer depth on SCL and SDA (must be 2 or more)
//
// Ports
//   CLK_IW    system clock, rising edge
//   RST_IW    synchronous active-high reset
//   SCL_IW    I2C clock from the bus (asynchronous)
//   SDA_IOW   I2C data, driven only as 1'b0 or 1'bz
//   ADDR_OW   address of the current/last accepted transaction
//   DATA_OW   last received data byte, held until the next one completes
//   VALID_OW  one-cycle pulse when DATA_OW is newly loaded
//   BUSY_OW   high from a detected START until a detected STOP
//   ERR_OW    one-cycle pulse when STOP cuts a data byte short
// ---------------------------------------------------------------------------
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK_IW,
    input  logic       RST_IW,
    input  logic       SCL_IW,
    inout  wire        SDA_IOW,
    output logic [6:0] ADDR_OW,
    output logic [7:0] DATA_OW,
    output logic       VALID_OW,
    output logic       BUSY_OW,
    output logic       ERR_OW
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclHist_q;
    logic                   sdaHist_q;

    state_t     state_q, state_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic       bitSeen_q, bitSeen_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       sdaDrive_q, sdaDrive_d;

    logic sclNow, sdaNow;
    logic sclRise, sclFall, sdaRise, sdaFall;
    logic startDet, stopDet;

    // Bring the asynchronous bus lines into the clock domain. The history flop
    // holds the previous synchronized value so edges can be detected. Reset
    // loads 1s so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge CLK_IW) begin
        if (RST_IW) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclHist_q <= 1'b1;
            sdaHist_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], SCL_IW};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], SDA_IOW};
            sclHist_q <= sclSync_q[SYNC_STAGES-1];
            sdaHist_q <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign sclNow   = sclSync_q[SYNC_STAGES-1];
    assign sdaNow   = sdaSync_q[SYNC_STAGES-1];
    assign sclRise  = sclNow & ~sclHist_q;
    assign sclFall  = ~sclNow & sclHist_q;
    assign sdaRise  = sdaNow & ~sdaHist_q;
    assign sdaFall  = ~sdaNow & sdaHist_q;
    assign startDet = sdaFall & sclNow;
    assign stopDet  = sdaRise & sclNow;

    // State and datapath registers.
    always_ff @(posedge CLK_IW) begin
        if (RST_IW) begin
            state_q    <= IDLE;
            bitCnt_q   <= 3'd0;
            bitSeen_q  <= 1'b0;
            shift_q    <= 8'd0;
            addr_q     <= 7'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            sdaDrive_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            bitSeen_q  <= bitSeen_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            sdaDrive_q <= sdaDrive_d;
        end
    end

    // Next-state logic. START/STOP override any SCL activity in the same
    // cycle. Bits are sampled on SCL rise, but a bit only counts as complete
    // on the following SCL fall (bitSeen_q pairs the two). That way the SCL
    // pulse belonging to a STOP or repeated START is never mistaken for a
    // received bit, and the fall right after START is ignored.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        bitSeen_d  = bitSeen_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        sdaDrive_d = sdaDrive_q;

        if (startDet) begin
            state_d    = ADDR;
            bitCnt_d   = 3'd0;
            bitSeen_d  = 1'b0;
            sdaDrive_d = 1'b0;
            busy_d     = 1'b1;
        end else if (stopDet) begin
            if ((state_q == DATA) && (bitCnt_q != 3'd0)) begin
                err_d = 1'b1;
            end
            state_d    = IDLE;
            bitSeen_d  = 1'b0;
            sdaDrive_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR, DATA: begin
                    if (sclRise) begin
                        shift_d   = {shift_q[6:0], sdaNow};
                        bitSeen_d = 1'b1;
                    end
                    if (sclFall && bitSeen_q) begin
                        bitSeen_d = 1'b0;
                        bitCnt_d  = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                // Only writes to our address are acknowledged.
                                if ((shift_q[7:1] == TARGET_ADDR) && !shift_q[0]) begin
                                    addr_d     = shift_q[7:1];
                                    state_d    = ADDR_ACK;
                                    sdaDrive_d = 1'b1;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else begin
                                data_d     = shift_q;
                                valid_d    = 1'b1;
                                state_d    = DATA_ACK;
                                sdaDrive_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // The fall that ends the ACK bit hands SDA back.
                    if (sclFall) begin
                        sdaDrive_d = 1'b0;
                        state_d    = DATA;
                        bitCnt_d   = 3'd0;
                        bitSeen_d  = 1'b0;
                    end
                end
                IGNORE: begin
                    sdaDrive_d = 1'b0;
                end
                default: begin
                    state_d    = IDLE;
                    sdaDrive_d = 1'b0;
                end
            endcase
        end
    end

    assign SDA_IOW  = sdaDrive_q ? 1'b0 : 1'bz;
    assign ADDR_OW  = addr_q;
    assign DATA_OW  = data_q;
    assign VALID_OW = valid_q;
    assign BUSY_OW  = busy_q;
    assign ERR_OW   = err_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_rx
//
// Bench for i2c_target_rx. A bit-banged I2C master drives SCL and an
// open-drain SDA (with pull-up). A transaction-level model tracks which bytes
// must be ACKed, which bytes must appear on DATA_OW, the accepted address and
// the expected number of ERR pulses. A monitor compares the DUT against that
// model every cycle; scenario endings add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_i2c_target_rx;

    localparam logic [6:0] TARGET = 7'h55;
    localparam int         Q      = 4;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic sdaMasterLow;
    wire  sdaBus;

    logic [6:0] addrOut;
    logic [7:0] dataOut;
    logic       validOut;
    logic       busyOut;
    logic       errOut;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] expQ [$];
    int         phase;          // 0 idle, 1 address expected, 2 accepted, 3 ignored
    logic [6:0] expAddr;
    logic [7:0] lastByte;
    int         partialBits;
    int         expErr;
    int         errCount;
    int         validCount;
    bit         curExpectAck;
    bit         ackAllowed;
    bit         busyCheck;
    bit         monitorOn;
    logic       prevValid;
    logic       prevErr;

    assign sdaBus = sdaMasterLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 clk = ~clk;

    i2c_target_rx #(
        .TARGET_ADDR(TARGET),
        .SYNC_STAGES(2)
    ) dut (
        .CLK_IW  (clk),
        .RST_IW  (rst),
        .SCL_IW  (scl),
        .SDA_IOW (sdaBus),
        .ADDR_OW (addrOut),
        .DATA_OW (dataOut),
        .VALID_OW(validOut),
        .BUSY_OW (busyOut),
        .ERR_OW  (errOut)
    );

    // Advance n clocks; inputs change 2ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (validOut) begin
                validCount++;
                if (expQ.size() == 0) begin
                    checkOutput("valid_unexpected", validOut, 1'b0);
                end else begin
                    checkOutput("data_ow", dataOut, expQ.pop_front());
                end
            end
            if (prevValid) checkOutput("valid_width", validOut, 1'b0);
            if (prevErr)   checkOutput("err_width", errOut, 1'b0);
            if (errOut) errCount++;
            if (!sdaMasterLow && !ackAllowed) checkOutput("sda_spurious", sdaBus, 1'b1);
            if (busyCheck) checkOutput("busy_ow", busyOut, 1'b1);
        end
        prevValid = validOut;
        prevErr   = errOut;
    end

    task automatic startCond();
        sdaMasterLow = 1'b1;
        tick(2 * Q);
        busyCheck = 1'b1;
        scl = 1'b0;
        tick(Q);
        phase       = 1;
        partialBits = 0;
    endtask

    task automatic repStart();
        sdaMasterLow = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sdaMasterLow = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
        phase       = 1;
        partialBits = 0;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        logic [7:0] sh;
        sh = b;
        for (int i = 0; i < n; i++) begin
            sdaMasterLow = ~sh[7];
            sh = sh << 1;
            tick(Q);
            scl = 1'b1;
            tick(2 * Q);
            if (i == 7) begin
                curExpectAck = (phase == 2) ||
                               (phase == 1 && b[7:1] == TARGET && b[0] == 1'b0);
                if (phase == 2) expQ.push_back(b);
                ackAllowed = curExpectAck;
                lastByte   = b;
            end
            scl = 1'b0;
            tick(Q);
        end
        partialBits = (n == 8) ? 0 : n;
    endtask

    task automatic ackBit();
        sdaMasterLow = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        checkOutput("ack_bit", sdaBus, curExpectAck ? 1'b0 : 1'b1);
        tick(Q);
        scl = 1'b0;
        tick(Q);
        ackAllowed = 1'b0;
        if (phase == 1) begin
            if (curExpectAck) begin
                phase   = 2;
                expAddr = lastByte[7:1];
            end else begin
                phase = 3;
            end
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        sendBits(b, 8);
        ackBit();
    endtask

    task automatic stopCond();
        busyCheck    = 1'b0;
        sdaMasterLow = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sdaMasterLow = 1'b0;
        tick(2 * Q);
        if (phase == 2 && partialBits > 0) expErr++;
        phase       = 0;
        partialBits = 0;
    endtask

    task automatic endCheck();
        tick(4);
        checkOutput("busy_after_stop", busyOut, 1'b0);
        checkOutput("expq_drained", expQ.size(), 0);
        checkOutput("err_count", errCount, expErr);
        checkOutput("addr_ow", addrOut, expAddr);
        errCount = 0;
        expErr   = 0;
    endtask

    task automatic applyStimulus(input int testId);
        validCount = 0;
        case (testId)
            0: begin
                startCond(); sendByte(8'h00); sendByte(8'hFF); stopCond();
                checkOutput("t030_valid_count", validCount, 0);
                checkOutput("t030_addr", addrOut, 7'h00);
                endCheck();
            end
            1: begin
                startCond(); sendByte(8'hAA); sendByte(8'hA5); stopCond();
                checkOutput("t029_valid_count", validCount, 1);
                checkOutput("t029_data", dataOut, 8'hA5);
                checkOutput("t029_addr", addrOut, 7'h55);
                endCheck();
            end
            2: begin
                startCond(); sendByte(8'hAB); stopCond();
                checkOutput("t031_valid_count", validCount, 0);
                checkOutput("t031_data_held", dataOut, 8'hA5);
                endCheck();
            end
            3: begin
                startCond(); sendByte(8'hAA); sendByte(8'hFF); sendByte(8'h00);
                repStart(); sendByte(8'hAA); sendByte(8'hAB); stopCond();
                checkOutput("t032_valid_count", validCount, 3);
                checkOutput("t032_data", dataOut, 8'hAB);
                endCheck();
            end
            4: begin
                startCond(); sendByte(8'hAA); sendBits(8'b1010_0000, 3); stopCond();
                checkOutput("t033_err_count", errCount, 1);
                checkOutput("t033_valid_count", validCount, 0);
                endCheck();
            end
            5: begin
                startCond(); sendByte(8'hAA); sendBits(8'h5A, 8);
                sdaMasterLow = 1'b0;
                tick(Q);
                scl = 1'b1;
                tick(Q);
                checkOutput("t034_ack_before_reset", sdaBus, 1'b0);
                busyCheck = 1'b0;
                rst = 1'b1;
                tick(1);
                ackAllowed = 1'b0;
                checkOutput("t034_sda_released", sdaBus, 1'b1);
                checkOutput("t034_addr", addrOut, 7'h00);
                checkOutput("t034_data", dataOut, 8'h00);
                checkOutput("t034_valid", validOut, 1'b0);
                checkOutput("t034_busy", busyOut, 1'b0);
                checkOutput("t034_err", errOut, 1'b0);
                phase       = 0;
                partialBits = 0;
                expAddr     = 7'h00;
                tick(2);
                rst = 1'b0;
                scl = 1'b0;
                tick(2 * Q);
                scl = 1'b1;
                tick(2 * Q);
                validCount = 0;
                startCond(); sendByte(8'hAA); sendByte(8'h3C); stopCond();
                checkOutput("t034_valid_count", validCount, 1);
                checkOutput("t034_data_after", dataOut, 8'h3C);
                checkOutput("t034_addr_after", addrOut, 7'h55);
                endCheck();
            end
            default: begin
            end
        endcase
    endtask

    // Bound the whole run so a stuck bench still reports.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        scl          = 1'b1;
        sdaMasterLow = 1'b0;
        phase        = 0;
        expAddr      = 7'h00;
        lastByte     = 8'h00;
        partialBits  = 0;
        expErr       = 0;
        errCount     = 0;
        validCount   = 0;
        curExpectAck = 1'b0;
        ackAllowed   = 1'b0;
        busyCheck    = 1'b0;
        monitorOn    = 1'b0;
        tick(3);
        checkOutput("rst_addr", addrOut, 7'h00);
        checkOutput("rst_data", dataOut, 8'h00);
        checkOutput("rst_valid", validOut, 1'b0);
        checkOutput("rst_busy", busyOut, 1'b0);
        checkOutput("rst_err", errOut, 1'b0);
        checkOutput("rst_sda", sdaBus, 1'b1);
        rst = 1'b0;
        tick(2);
        monitorOn = 1'b1;
        for (int t = 0; t < 6; t++) begin
            applyStimulus(t);
            tick(2 * Q);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h55: the 7-bit address the block acknowledges.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on SCL and SDA (minimum 2).
REQ-003 SHALL have port CLK_IW, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST_IW, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port SCL_IW, input, 1 bit: I2C clock from the bus; asynchronous to CLK_IW.
REQ-006 SHALL have port SDA_IOW, inout, 1 bit: I2C data; the block drives only 1'b0 or 1'bz (open-drain).
REQ-007 SHALL have port ADDR_OW, output, 7 bits: address of the current/last accepted transaction.
REQ-008 SHALL have port DATA_OW, output, 8 bits: last received data byte; held until the next byte completes.
REQ-009 SHALL have port VALID_OW, output, 1 bit: one-cycle pulse, DATA_OW newly valid.
REQ-010 SHALL have port BUSY_OW, output, 1 bit: high from a detected START until a detected STOP.
REQ-011 SHALL have port ERR_OW, output, 1 bit: one-cycle pulse on a STOP inside a partially received byte.

Function
REQ-012 SCL and SDA SHALL pass through SYNC_STAGES flops plus one history flop; edges SHALL be detected by comparing the last sync stage with the history flop.
REQ-013 START SHALL be the synchronized SDA falling while synchronized SCL is high; STOP SHALL be the synchronized SDA rising while SCL is high.
REQ-014 Correct operation SHALL be required for SCL high and low phases each of at least SYNC_STAGES+3 CLK_IW cycles.
REQ-015 States SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-016 IDLE: a START SHALL go to ADDR with the bit counter cleared; all other bus activity SHALL be ignored.
REQ-017 ADDR/DATA: SDA SHALL be sampled on each synchronized SCL rising edge, MSB first, into a shift register; the 3-bit counter SHALL increment per bit.
REQ-018 After the 8th address bit: {7 bits, R/W}. If the address equals TARGET_ADDR and R/W=0, the block SHALL load ADDR_OW and, on the next SCL falling edge, enter ADDR_ACK; otherwise it SHALL enter IGNORE.
REQ-019 ADDR_ACK/DATA_ACK: SDA SHALL be driven low from the SCL falling edge that ends bit 8 until the SCL falling edge that ends the ACK bit, then released (z); the state SHALL then go to DATA.
REQ-020 After the 8th data bit, on the following SCL falling edge: DATA_OW SHALL load the byte, VALID_OW SHALL pulse for exactly one cycle, and the state SHALL go to DATA_ACK.
REQ-021 The bus master SHALL be able to send any number of data bytes; each byte SHALL produce one VALID_OW pulse and one ACK.
REQ-022 IGNORE: SDA SHALL remain released until STOP or START; reads (R/W=1) are not supported and SHALL be NACKed by release.
REQ-023 A START (repeated START) in any non-IDLE state SHALL go to ADDR, clear the counter, and release SDA in the same cycle; BUSY_OW SHALL stay high.
REQ-024 A STOP in any state SHALL go to IDLE, release SDA, and clear BUSY_OW on the next cycle.
REQ-025 If a STOP occurs in DATA with counter 1..7, ERR_OW SHALL pulse for one cycle and VALID_OW SHALL NOT pulse.
REQ-026 When START/STOP and an SCL edge are detected in the same cycle, START/STOP SHALL take priority.

Reset
REQ-027 While RST_IW is high at a CLK_IW rising edge: state SHALL be IDLE; ADDR_OW=0, DATA_OW=0, VALID_OW=0, BUSY_OW=0, ERR_OW=0; SDA_IOW=z; counter and shift register =0; synchronizer flops SHALL load 1 (idle bus).
REQ-028 Reset asserted mid-transfer, including during ACK, SHALL release SDA on the first reset clock edge; after reset the block SHALL wait for a new START.

Verification
REQ-029 START, 0x55+W, 0xA5, STOP -> SDA low during both ACK bits; one VALID_OW pulse with DATA_OW=0xA5; ADDR_OW=0x55; BUSY_OW low after STOP.
REQ-030 START, 0x00+W, 0xFF, STOP -> SDA never driven low by the block; no VALID_OW; ADDR_OW stays 0.
REQ-031 START, 0x55+R, STOP -> no ACK; state IGNORE until STOP; no VALID_OW.
REQ-032 START, 0x55+W, 0xFF, 0x00, repeated START, 0x55+W, 0xAB, STOP -> three VALID_OW pulses with DATA_OW 0xFF, 0x00, 0xAB in order; BUSY_OW high throughout.
REQ-033 START, 0x55+W, 3 data bits, STOP -> exactly one ERR_OW pulse; no VALID_OW; BUSY_OW low.
REQ-034 RST_IW asserted during the data ACK bit -> SDA z on the next edge; all outputs 0; a following full 0x55/0x3C write succeeds.
